// File: rtl/mlp_layer_sequencer.sv
// Control sequencer that time-shares one MAC unit across a three-layer MLP
// (N_IN -> N_H1 -> N_H2 -> N_OUT), walking weight/bias ROM addresses and tracking argmax.
module mlp_layer_sequencer #(
    parameter int N_IN  = 784,
    parameter int N_H1  = 200,
    parameter int N_H2  = 50,
    parameter int N_OUT = 10,
    parameter int DW    = 16,
    parameter int WAW   = 18,
    parameter int AAW   = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [3:0]     result_class_o,
    output logic [1:0]     act_rd_bank_o,
    output logic [AAW-1:0] act_rd_addr_o,
    output logic [WAW-1:0] w_rd_addr_o,
    output logic [8:0]     b_rd_addr_o,
    output logic           mac_clr_o,
    output logic           mac_en_o,
    output logic           mac_last_o,
    output logic           relu_en_o,
    input  logic           mac_valid_i,
    input  logic [DW-1:0]  mac_out_i,
    output logic           act_wr_en_o,
    output logic [1:0]     act_wr_bank_o,
    output logic [AAW-1:0] act_wr_addr_o,
    output logic [DW-1:0]  act_wr_data_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACC   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [AAW-1:0] IN_LAST  = AAW'(N_IN - 1);
    localparam logic [AAW-1:0] H1_LAST  = AAW'(N_H1 - 1);
    localparam logic [AAW-1:0] H2_LAST  = AAW'(N_H2 - 1);
    localparam logic [AAW-1:0] OUT_LAST = AAW'(N_OUT - 1);

    function automatic logic [AAW-1:0] fan_in_last(input logic [1:0] layer);
        case (layer)
            2'd0:    return IN_LAST;
            2'd1:    return H1_LAST;
            default: return H2_LAST;
        endcase
    endfunction

    function automatic logic [AAW-1:0] fan_out_last(input logic [1:0] layer);
        case (layer)
            2'd0:    return H1_LAST;
            2'd1:    return H2_LAST;
            default: return OUT_LAST;
        endcase
    endfunction

    logic [2:0]     state_q,    state_d;
    logic [1:0]     layer_q,    layer_d;
    logic [AAW-1:0] neuron_q,   neuron_d;
    logic [AAW-1:0] k_q,        k_d;
    logic [WAW-1:0] w_q,        w_d;
    logic [8:0]     b_q,        b_d;
    logic [DW-1:0]  data_q,     data_d;
    logic [DW-1:0]  best_val_q, best_val_d;
    logic [3:0]     best_idx_q, best_idx_d;
    logic [3:0]     result_q,   result_d;
    logic           busy_q,     busy_d;
    logic           done_q,     done_d;
    logic           mac_en_q,   mac_en_d;
    logic           mac_clr_q,  mac_clr_d;
    logic           mac_last_q, mac_last_d;
    logic           relu_q,     relu_d;
    logic           wr_en_q,    wr_en_d;
    logic [1:0]     wr_bank_q,  wr_bank_d;
    logic [AAW-1:0] wr_addr_q,  wr_addr_d;

    // Sequencing: state, loop counters, captured result and running argmax
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        neuron_d   = neuron_q;
        k_d        = k_q;
        w_d        = w_q;
        b_d        = b_q;
        data_d     = data_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_ACC;
                    layer_d  = 2'd0;
                    neuron_d = {AAW{1'b0}};
                    k_d      = {AAW{1'b0}};
                    w_d      = {WAW{1'b0}};
                    b_d      = 9'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                // Weights are neuron-major and layer-concatenated, so the address just runs on
                w_d = w_q + WAW'(1);
                if (k_q == fan_in_last(layer_q)) begin
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + AAW'(1);
                end
            end
            S_WAIT: begin
                if (mac_valid_i) begin
                    data_d  = mac_out_i;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WRITE: begin
                if (layer_q == 2'd2 &&
                    (neuron_q == {AAW{1'b0}} || $signed(data_q) > $signed(best_val_q))) begin
                    best_val_d = data_q;
                    best_idx_d = neuron_q[3:0];
                end else begin
                    best_val_d = best_val_q;
                end
                b_d = b_q + 9'd1;
                if (neuron_q != fan_out_last(layer_q)) begin
                    neuron_d = neuron_q + AAW'(1);
                    k_d      = {AAW{1'b0}};
                    state_d  = S_ACC;
                end else if (layer_q == 2'd2) begin
                    result_d = best_idx_d;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                layer_d  = layer_q + 2'd1;
                neuron_d = {AAW{1'b0}};
                k_d      = {AAW{1'b0}};
                state_d  = S_ACC;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output strobes decoded from the next state so every output leaves a flop
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        mac_en_d   = (state_d == S_ACC);
        mac_clr_d  = mac_en_d && (k_d == {AAW{1'b0}});
        mac_last_d = mac_en_d && (k_d == fan_in_last(layer_d));
        relu_d     = ((state_d == S_ACC) || (state_d == S_WAIT)) && (layer_d != 2'd2);
        wr_en_d    = (state_d == S_WRITE);
        wr_bank_d  = wr_en_d ? (layer_d + 2'd1) : 2'd0;
        wr_addr_d  = wr_en_d ? neuron_d : {AAW{1'b0}};
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            layer_q    <= 2'd0;
            neuron_q   <= {AAW{1'b0}};
            k_q        <= {AAW{1'b0}};
            w_q        <= {WAW{1'b0}};
            b_q        <= 9'd0;
            data_q     <= {DW{1'b0}};
            best_val_q <= {DW{1'b0}};
            best_idx_q <= 4'd0;
            result_q   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            relu_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_bank_q  <= 2'd0;
            wr_addr_q  <= {AAW{1'b0}};
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            neuron_q   <= neuron_d;
            k_q        <= k_d;
            w_q        <= w_d;
            b_q        <= b_d;
            data_q     <= data_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
            mac_last_q <= mac_last_d;
            relu_q     <= relu_d;
            wr_en_q    <= wr_en_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign result_class_o = result_q;
    assign act_rd_bank_o  = layer_q;
    assign act_rd_addr_o  = k_q;
    assign w_rd_addr_o    = w_q;
    assign b_rd_addr_o    = b_q;
    assign mac_clr_o      = mac_clr_q;
    assign mac_en_o       = mac_en_q;
    assign mac_last_o     = mac_last_q;
    assign relu_en_o      = relu_q;
    assign act_wr_en_o    = wr_en_q;
    assign act_wr_bank_o  = wr_bank_q;
    assign act_wr_addr_o  = wr_addr_q;
    assign act_wr_data_o  = data_q;

endmodule
